multi_cycle_controller: RTL and testbench
=========================================

MULTI_CYCLE_CONTROLLER -- requirements
Module: multi_cycle_controller

Interface
REQ-001 SHALL expose: clk  in  1  single clock; all state updates on rising edge.
REQ-002 SHALL expose: reset  in  1  asynchronous, active-high reset.
REQ-003 SHALL expose: opcode  in  7  instruction opcode from IR.
REQ-004 SHALL expose: alu_bcond  in  1  branch-taken flag from ALU in EX.
REQ-005 SHALL expose: halt_req  in  1  register x17 equals 10, sampled during ID of ECALL.
REQ-006 SHALL expose: mem_ready  in  1  memory completes the current access this cycle.
REQ-007 SHALL expose: pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write, reg_write  out  1 each  datapath strobes.
REQ-008 SHALL expose: pc_source  out  1  0 = ALU result, 1 = ALUOut.
REQ-009 SHALL expose: alu_src_a  out  2  00 = PC, 01 = old_pc, 10 = rs1.
REQ-010 SHALL expose: alu_src_b  out  2  00 = rs2, 01 = constant 4, 10 = immediate.
REQ-011 SHALL expose: alu_op  out  2  00 = add, 01 = branch compare, 10 = funct decode.
REQ-012 SHALL expose: wb_sel  out  2  00 = ALUOut, 01 = MDR, 10 = PC.
REQ-013 SHALL expose: is_halted  out  1  sticky halt flag.

Function
REQ-014 SHALL implement FSM states IF, ID, EX, MEM, WB, HALT, with the state held in a register.
REQ-015 SHALL make outputs combinational from state, opcode, alu_bcond and mem_ready; unlisted outputs are 0.
REQ-016 IF: mem_read=1, i_or_d=0, alu_src_a=00, alu_src_b=01, alu_op=00, pc_source=0.
REQ-017 IF with mem_ready=1: ir_write=1, pc_write=1, go to ID; with mem_ready=0: stay in IF, ir_write=0, pc_write=0.
REQ-018 ID: alu_src_a=01, alu_src_b=10, alu_op=00 (ALUOut gets the branch/JAL target).
REQ-019 ID with opcode ECALL (1110011): if halt_req=1, go to HALT; otherwise go to IF.
REQ-020 ID with any other opcode: go to EX.
REQ-021 EX R-type (0110011): alu_src_a=10, alu_src_b=00, alu_op=10, then WB.
REQ-022 EX I-arith (0010011): alu_src_a=10, alu_src_b=10, alu_op=10, then WB.
REQ-023 EX load/store (0000011/0100011): alu_src_a=10, alu_src_b=10, alu_op=00, then MEM.
REQ-024 EX branch (1100011): alu_src_a=10, alu_src_b=00, alu_op=01, pc_write_cond=alu_bcond, pc_source=1, then IF.
REQ-025 EX JAL (1101111): pc_write=1, pc_source=1, reg_write=1, wb_sel=10, then IF.
REQ-026 EX JALR (1100111): alu_src_a=10, alu_src_b=10, alu_op=00, pc_write=1, pc_source=0, reg_write=1, wb_sel=10, then IF.
REQ-027 MEM: i_or_d=1, with mem_read=1 for loads and mem_write=1 for stores.
REQ-028 MEM with mem_ready=0: stay in MEM; with mem_ready=1: loads go to WB, stores go to IF.
REQ-029 WB: reg_write=1; wb_sel=01 for loads, 00 otherwise; then IF.
REQ-030 Undefined opcode in ID: go to IF with no register or memory write (treated as NOP).
REQ-031 HALT: absorbing until reset; all strobes 0; is_halted=1.
REQ-032 Strobes SHALL never assert simultaneously with a stalled access: pc_write, ir_write and reg_write SHALL be 0 whenever the state waits on mem_ready=0.

Reset
REQ-033 Reset assertion SHALL force state IF and is_halted=0 immediately, independent of clk, including mid-access in MEM.
REQ-034 While reset is held: mem_read=1, i_or_d=0, all write strobes 0.

Structure
REQ-035 SHALL place the state encoding, opcode constants and the alu_op, wb_sel and alu_src encodings in a shared package.
REQ-036 SHALL split the output decode into one combinational sub-module, mc_ctrl_decode; the state register and next-state logic stay in the top module.

Verification
REQ-037 ADD (0110011) with mem_ready=1 always -> IF, ID, EX, WB; exactly one reg_write pulse, with wb_sel=00 in cycle 4.
REQ-038 LW with mem_ready low for 3 MEM cycles -> MEM held 4 cycles; reg_write=1, wb_sel=01 only in the following WB.
REQ-039 BEQ with alu_bcond=1, then alu_bcond=0 -> pc_write_cond 1, then 0; 3 cycles per instruction; no reg_write.
REQ-040 ECALL with halt_req=1 -> HALT after ID; is_halted=1 and no strobes for 20 further cycles.
REQ-041 ECALL with halt_req=0 -> returns to IF after ID.
REQ-042 Reset pulse mid-MEM of SW -> state IF on the same edge with mem_write=0; the next fetch proceeds normally.

Source files
------------

// File: rtl/multi_cycle_controller_pkg.sv
// Shared encodings for the multi-cycle RISC-V controller: FSM states, opcodes,
// datapath mux selects and the bundle of control strobes driven each cycle.
package multi_cycle_controller_pkg;

    localparam logic [2:0] ST_IF   = 3'd0;
    localparam logic [2:0] ST_ID   = 3'd1;
    localparam logic [2:0] ST_EX   = 3'd2;
    localparam logic [2:0] ST_MEM  = 3'd3;
    localparam logic [2:0] ST_WB   = 3'd4;
    localparam logic [2:0] ST_HALT = 3'd5;

    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_IARITH = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_ECALL  = 7'b1110011;

    localparam logic [1:0] ALU_OP_ADD    = 2'b00;
    localparam logic [1:0] ALU_OP_BRANCH = 2'b01;
    localparam logic [1:0] ALU_OP_FUNCT  = 2'b10;

    localparam logic [1:0] SRC_A_PC    = 2'b00;
    localparam logic [1:0] SRC_A_OLDPC = 2'b01;
    localparam logic [1:0] SRC_A_RS1   = 2'b10;

    localparam logic [1:0] SRC_B_RS2  = 2'b00;
    localparam logic [1:0] SRC_B_FOUR = 2'b01;
    localparam logic [1:0] SRC_B_IMM  = 2'b10;

    localparam logic [1:0] WB_ALUOUT = 2'b00;
    localparam logic [1:0] WB_MDR    = 2'b01;
    localparam logic [1:0] WB_PC     = 2'b10;

    localparam logic PC_SRC_ALU    = 1'b0;
    localparam logic PC_SRC_ALUOUT = 1'b1;

    typedef struct packed {
        logic       pcWrite;
        logic       pcWriteCond;
        logic       iOrD;
        logic       memRead;
        logic       memWrite;
        logic       irWrite;
        logic       regWrite;
        logic       pcSource;
        logic [1:0] aluSrcA;
        logic [1:0] aluSrcB;
        logic [1:0] aluOp;
        logic [1:0] wbSel;
        logic       isHalted;
    } ctrlBundle_t;

    // Opcodes that have an EX phase; anything else falling out of ID is a NOP.
    function automatic logic hasExecPhase(input logic [6:0] op);
        case (op)
            OP_RTYPE, OP_IARITH, OP_LOAD, OP_STORE,
            OP_BRANCH, OP_JAL, OP_JALR: hasExecPhase = 1'b1;
            default:                    hasExecPhase = 1'b0;
        endcase
    endfunction

    function automatic logic isMemAccess(input logic [6:0] op);
        isMemAccess = (op == OP_LOAD) || (op == OP_STORE);
    endfunction

    function automatic logic needsWriteback(input logic [6:0] op);
        needsWriteback = (op == OP_RTYPE) || (op == OP_IARITH);
    endfunction

endpackage

// File: rtl/mc_ctrl_decode.sv
// Combinational output decode for the multi-cycle controller: maps the current
// state, opcode and datapath handshakes onto the datapath strobes and selects.
module mc_ctrl_decode
    import multi_cycle_controller_pkg::*;
(
    input  logic       reset,
    input  logic [2:0] state,
    input  logic [6:0] opcode,
    input  logic       alu_bcond,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_write,
    output logic       pc_source,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] wb_sel,
    output logic       is_halted
);

    ctrlBundle_t ctrl;
    logic        fetchDone;

    // The state register sits in IF while reset is held, so masking the
    // handshake here is what keeps the fetch strobes quiet during reset.
    assign fetchDone = mem_ready & ~reset;

    always_comb begin
        ctrl = '0;
        case (state)
            ST_IF: begin
                ctrl.memRead  = 1'b1;
                ctrl.iOrD     = 1'b0;
                ctrl.aluSrcA  = SRC_A_PC;
                ctrl.aluSrcB  = SRC_B_FOUR;
                ctrl.aluOp    = ALU_OP_ADD;
                ctrl.pcSource = PC_SRC_ALU;
                ctrl.irWrite  = fetchDone;
                ctrl.pcWrite  = fetchDone;
            end
            ST_ID: begin
                ctrl.aluSrcA = SRC_A_OLDPC;
                ctrl.aluSrcB = SRC_B_IMM;
                ctrl.aluOp   = ALU_OP_ADD;
            end
            ST_EX: begin
                case (opcode)
                    OP_RTYPE: begin
                        ctrl.aluSrcA = SRC_A_RS1;
                        ctrl.aluSrcB = SRC_B_RS2;
                        ctrl.aluOp   = ALU_OP_FUNCT;
                    end
                    OP_IARITH: begin
                        ctrl.aluSrcA = SRC_A_RS1;
                        ctrl.aluSrcB = SRC_B_IMM;
                        ctrl.aluOp   = ALU_OP_FUNCT;
                    end
                    OP_LOAD, OP_STORE: begin
                        ctrl.aluSrcA = SRC_A_RS1;
                        ctrl.aluSrcB = SRC_B_IMM;
                        ctrl.aluOp   = ALU_OP_ADD;
                    end
                    OP_BRANCH: begin
                        ctrl.aluSrcA     = SRC_A_RS1;
                        ctrl.aluSrcB     = SRC_B_RS2;
                        ctrl.aluOp       = ALU_OP_BRANCH;
                        ctrl.pcWriteCond = alu_bcond;
                        ctrl.pcSource    = PC_SRC_ALUOUT;
                    end
                    OP_JAL: begin
                        ctrl.pcWrite  = 1'b1;
                        ctrl.pcSource = PC_SRC_ALUOUT;
                        ctrl.regWrite = 1'b1;
                        ctrl.wbSel    = WB_PC;
                    end
                    OP_JALR: begin
                        ctrl.aluSrcA  = SRC_A_RS1;
                        ctrl.aluSrcB  = SRC_B_IMM;
                        ctrl.aluOp    = ALU_OP_ADD;
                        ctrl.pcWrite  = 1'b1;
                        ctrl.pcSource = PC_SRC_ALU;
                        ctrl.regWrite = 1'b1;
                        ctrl.wbSel    = WB_PC;
                    end
                    default: ctrl = '0;
                endcase
            end
            ST_MEM: begin
                ctrl.iOrD     = 1'b1;
                ctrl.memRead  = (opcode == OP_LOAD);
                ctrl.memWrite = (opcode == OP_STORE);
            end
            ST_WB: begin
                ctrl.regWrite = 1'b1;
                ctrl.wbSel    = (opcode == OP_LOAD) ? WB_MDR : WB_ALUOUT;
            end
            ST_HALT: begin
                ctrl.isHalted = 1'b1;
            end
            default: ctrl = '0;
        endcase
    end

    assign pc_write      = ctrl.pcWrite;
    assign pc_write_cond = ctrl.pcWriteCond;
    assign i_or_d        = ctrl.iOrD;
    assign mem_read      = ctrl.memRead;
    assign mem_write     = ctrl.memWrite;
    assign ir_write      = ctrl.irWrite;
    assign reg_write     = ctrl.regWrite;
    assign pc_source     = ctrl.pcSource;
    assign alu_src_a     = ctrl.aluSrcA;
    assign alu_src_b     = ctrl.aluSrcB;
    assign alu_op        = ctrl.aluOp;
    assign wb_sel        = ctrl.wbSel;
    assign is_halted     = ctrl.isHalted;

endmodule

// File: rtl/multi_cycle_controller.sv
// Multi-cycle RISC-V control FSM (IF/ID/EX/MEM/WB/HALT): owns the state
// register and sequencing; the strobe decode lives in mc_ctrl_decode.
module multi_cycle_controller
    import multi_cycle_controller_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] opcode,
    input  logic       alu_bcond,
    input  logic       halt_req,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_write,
    output logic       pc_source,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] wb_sel,
    output logic       is_halted
);

    logic [2:0] state;
    logic [2:0] nextState;

    // Reset is asynchronous so an access stuck in MEM is abandoned at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IF;
        end else begin
            state <= nextState;
        end
    end

    // Sequencing: stalls in IF and MEM wait on mem_ready, HALT only leaves on reset.
    always_comb begin
        nextState = ST_IF;
        case (state)
            ST_IF: begin
                nextState = mem_ready ? ST_ID : ST_IF;
            end
            ST_ID: begin
                if (opcode == OP_ECALL) begin
                    nextState = halt_req ? ST_HALT : ST_IF;
                end else if (hasExecPhase(opcode)) begin
                    nextState = ST_EX;
                end else begin
                    nextState = ST_IF;
                end
            end
            ST_EX: begin
                if (isMemAccess(opcode)) begin
                    nextState = ST_MEM;
                end else if (needsWriteback(opcode)) begin
                    nextState = ST_WB;
                end else begin
                    nextState = ST_IF;
                end
            end
            ST_MEM: begin
                if (!mem_ready) begin
                    nextState = ST_MEM;
                end else if (opcode == OP_LOAD) begin
                    nextState = ST_WB;
                end else begin
                    nextState = ST_IF;
                end
            end
            ST_WB:   nextState = ST_IF;
            ST_HALT: nextState = ST_HALT;
            default: nextState = ST_IF;
        endcase
    end

    mc_ctrl_decode decodeUnit (
        .reset         (reset),
        .state         (state),
        .opcode        (opcode),
        .alu_bcond     (alu_bcond),
        .mem_ready     (mem_ready),
        .pc_write      (pc_write),
        .pc_write_cond (pc_write_cond),
        .i_or_d        (i_or_d),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .ir_write      (ir_write),
        .reg_write     (reg_write),
        .pc_source     (pc_source),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .alu_op        (alu_op),
        .wb_sel        (wb_sel),
        .is_halted     (is_halted)
    );

endmodule

// File: tb/tb_multi_cycle_controller.sv
// Self-checking bench for multi_cycle_controller: a phase-level instruction model
// is compared against every output on every cycle, plus directed literal checks.
module tb_multi_cycle_controller;

    localparam logic [6:0] ADD   = 7'b0110011;
    localparam logic [6:0] ADDI  = 7'b0010011;
    localparam logic [6:0] LW    = 7'b0000011;
    localparam logic [6:0] SW    = 7'b0100011;
    localparam logic [6:0] BEQ   = 7'b1100011;
    localparam logic [6:0] JAL   = 7'b1101111;
    localparam logic [6:0] JALR  = 7'b1100111;
    localparam logic [6:0] ECALL = 7'b1110011;
    localparam logic [6:0] UNDEF = 7'b0000000;

    typedef enum int {mIF, mID, mEX, mMEM, mWB, mHALT} mphase_t;

    logic       clk;
    logic       reset = 1'b1;
    logic [6:0] opcode = 7'b0;
    logic       alu_bcond = 1'b0;
    logic       halt_req = 1'b0;
    logic       mem_ready = 1'b0;
    logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write;
    logic       ir_write, reg_write, pc_source, is_halted;
    logic [1:0] alu_src_a, alu_src_b, alu_op, wb_sel;

    int      compared = 0;
    int      mismatched = 0;
    int      regWriteSeen = 0;
    int      snapshot;
    mphase_t phase = mIF;

    multi_cycle_controller dut (
        .clk           (clk),
        .reset         (reset),
        .opcode        (opcode),
        .alu_bcond     (alu_bcond),
        .halt_req      (halt_req),
        .mem_ready     (mem_ready),
        .pc_write      (pc_write),
        .pc_write_cond (pc_write_cond),
        .i_or_d        (i_or_d),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .ir_write      (ir_write),
        .reg_write     (reg_write),
        .pc_source     (pc_source),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .alu_op        (alu_op),
        .wb_sel        (wb_sel),
        .is_halted     (is_halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected outputs for one instruction phase, straight from the control table.
    function automatic logic [16:0] expOut(mphase_t ph, logic [6:0] op, logic bc,
                                           logic rdy, logic rst);
        logic pw, pwc, iod, mr, mw, irw, rw, ps, h;
        logic [1:0] sa, sb, aop, wb;
        {pw, pwc, iod, mr, mw, irw, rw, ps, h} = '0;
        {sa, sb, aop, wb} = '0;
        case (ph)
            mIF: begin
                mr = 1'b1; sb = 2'b01;
                irw = rdy && !rst; pw = rdy && !rst;
            end
            mID: begin sa = 2'b01; sb = 2'b10; end
            mEX: begin
                if (op == ADD)  begin sa = 2'b10; sb = 2'b00; aop = 2'b10; end
                if (op == ADDI) begin sa = 2'b10; sb = 2'b10; aop = 2'b10; end
                if (op == LW || op == SW) begin sa = 2'b10; sb = 2'b10; end
                if (op == BEQ)  begin sa = 2'b10; aop = 2'b01; pwc = bc; ps = 1'b1; end
                if (op == JAL)  begin pw = 1'b1; ps = 1'b1; rw = 1'b1; wb = 2'b10; end
                if (op == JALR) begin
                    sa = 2'b10; sb = 2'b10; pw = 1'b1; rw = 1'b1; wb = 2'b10;
                end
            end
            mMEM: begin iod = 1'b1; mr = (op == LW); mw = (op == SW); end
            mWB:  begin rw = 1'b1; wb = (op == LW) ? 2'b01 : 2'b00; end
            mHALT: h = 1'b1;
            default: ;
        endcase
        return {pw, pwc, iod, mr, mw, irw, rw, ps, sa, sb, aop, wb, h};
    endfunction

    // Instruction-level sequencing model: which phase the controller must be in.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            phase <= mIF;
        end else begin
            case (phase)
                mIF:  phase <= mem_ready ? mID : mIF;
                mID: begin
                    if (opcode == ECALL) phase <= halt_req ? mHALT : mIF;
                    else if (opcode inside {ADD, ADDI, LW, SW, BEQ, JAL, JALR}) phase <= mEX;
                    else phase <= mIF;
                end
                mEX: begin
                    if (opcode == LW || opcode == SW) phase <= mMEM;
                    else if (opcode == ADD || opcode == ADDI) phase <= mWB;
                    else phase <= mIF;
                end
                mMEM: phase <= !mem_ready ? mMEM : ((opcode == LW) ? mWB : mIF);
                mWB:   phase <= mIF;
                mHALT: phase <= mHALT;
                default: phase <= mIF;
            endcase
        end
    end

    task automatic checkOutput(input string name, input logic [16:0] actual,
                               input logic [16:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s at %0t: got %0h expected %0h", name, $time, actual, expected);
        end
    endtask

    // Per-cycle comparison of the full output vector against the model.
    always @(negedge clk) begin
        checkOutput("cycleModel",
                    {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
                     reg_write, pc_source, alu_src_a, alu_src_b, alu_op, wb_sel, is_halted},
                    expOut(phase, opcode, alu_bcond, mem_ready, reset));
        if (reg_write === 1'b1) regWriteSeen++;
    end

    task automatic applyStimulus(input logic [6:0] op, input logic bc,
                                 input logic hr, input logic rdy);
        opcode = op; alu_bcond = bc; halt_req = hr; mem_ready = rdy;
        #1;
    endtask

    task automatic stepClock();
        @(posedge clk);
        #1;
    endtask

    task automatic cycle(input logic [6:0] op, input logic bc, input logic hr, input logic rdy);
        applyStimulus(op, bc, hr, rdy);
        stepClock();
    endtask

    initial begin
        applyStimulus(ADD, 1'b0, 1'b0, 1'b1);
        checkOutput("resetHeldStrobes",
                    17'({mem_read, i_or_d, pc_write, ir_write, reg_write, mem_write}), 17'b100000);
        stepClock();
        stepClock();
        reset = 1'b0;

        snapshot = regWriteSeen;
        cycle(ADD, 1'b0, 1'b0, 1'b1);
        cycle(ADD, 1'b0, 1'b0, 1'b1);
        cycle(ADD, 1'b0, 1'b0, 1'b1);
        applyStimulus(ADD, 1'b0, 1'b0, 1'b1);
        checkOutput("addWbSel", 17'({reg_write, wb_sel}), 17'b100);
        stepClock();
        checkOutput("addRegWriteCount", 17'(regWriteSeen - snapshot), 17'd1);

        cycle(LW, 1'b0, 1'b0, 1'b1);
        cycle(LW, 1'b0, 1'b0, 1'b1);
        cycle(LW, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(LW, 1'b0, 1'b0, (i == 3));
            checkOutput("lwMemHold",
                        17'({i_or_d, mem_read, mem_write, reg_write, pc_write, ir_write}), 17'b110000);
            stepClock();
        end
        applyStimulus(LW, 1'b0, 1'b0, 1'b1);
        checkOutput("lwWb", 17'({reg_write, wb_sel}), 17'b101);
        stepClock();

        snapshot = regWriteSeen;
        for (int b = 1; b >= 0; b--) begin
            cycle(BEQ, 1'(b), 1'b0, 1'b1);
            cycle(BEQ, 1'(b), 1'b0, 1'b1);
            applyStimulus(BEQ, 1'(b), 1'b0, 1'b1);
            checkOutput("beqCond", 17'({pc_write_cond, pc_source, alu_op}), 17'({1'(b), 3'b101}));
            stepClock();
        end
        checkOutput("beqNoRegWrite", 17'(regWriteSeen - snapshot), 17'd0);

        for (int i = 0; i < 2; i++) begin
            applyStimulus(ADDI, 1'b0, 1'b0, 1'b0);
            checkOutput("fetchStall", 17'({ir_write, pc_write, mem_read}), 17'b001);
            stepClock();
        end
        cycle(ADDI, 1'b0, 1'b0, 1'b1);
        cycle(ADDI, 1'b0, 1'b0, 1'b1);
        cycle(ADDI, 1'b0, 1'b0, 1'b1);
        cycle(ADDI, 1'b0, 1'b0, 1'b1);

        cycle(ECALL, 1'b0, 1'b0, 1'b1);
        cycle(ECALL, 1'b0, 1'b0, 1'b1);
        applyStimulus(ECALL, 1'b0, 1'b0, 1'b0);
        checkOutput("ecallReturn", 17'({mem_read, i_or_d, is_halted, alu_src_b}), 17'b10001);
        stepClock();

        snapshot = regWriteSeen;
        cycle(UNDEF, 1'b0, 1'b0, 1'b1);
        cycle(UNDEF, 1'b0, 1'b0, 1'b1);
        applyStimulus(UNDEF, 1'b0, 1'b0, 1'b0);
        checkOutput("undefNop", 17'({mem_read, i_or_d, mem_write, 5'(regWriteSeen - snapshot)}),
                    17'b10000000);
        stepClock();

        cycle(JAL, 1'b0, 1'b0, 1'b1);
        cycle(JAL, 1'b0, 1'b0, 1'b1);
        applyStimulus(JAL, 1'b0, 1'b0, 1'b1);
        checkOutput("jalEx", 17'({pc_write, pc_source, reg_write, wb_sel}), 17'b11110);
        stepClock();
        cycle(JALR, 1'b0, 1'b0, 1'b1);
        cycle(JALR, 1'b0, 1'b0, 1'b1);
        applyStimulus(JALR, 1'b0, 1'b0, 1'b1);
        checkOutput("jalrEx", 17'({pc_write, pc_source, reg_write, wb_sel, alu_src_a}), 17'b1011010);
        stepClock();

        cycle(SW, 1'b0, 1'b0, 1'b1);
        cycle(SW, 1'b0, 1'b0, 1'b1);
        cycle(SW, 1'b0, 1'b0, 1'b1);
        applyStimulus(SW, 1'b0, 1'b0, 1'b0);
        checkOutput("swMem", 17'({mem_write, mem_read, i_or_d}), 17'b101);
        stepClock();
        applyStimulus(SW, 1'b0, 1'b0, 1'b0);
        reset = 1'b1;
        #1;
        checkOutput("resetMidMem", 17'({mem_write, mem_read, i_or_d, is_halted}), 17'b0100);
        reset = 1'b0;
        stepClock();
        applyStimulus(ADD, 1'b0, 1'b0, 1'b1);
        checkOutput("fetchAfterReset", 17'({ir_write, pc_write, mem_read}), 17'b111);
        stepClock();
        cycle(ADD, 1'b0, 1'b0, 1'b1);
        cycle(ADD, 1'b0, 1'b0, 1'b1);
        cycle(ADD, 1'b0, 1'b0, 1'b1);

        cycle(ECALL, 1'b0, 1'b1, 1'b1);
        cycle(ECALL, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 20; i++) begin
            applyStimulus(7'($urandom_range(0, 127)), 1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            checkOutput("haltQuiet",
                        17'({is_halted, pc_write, pc_write_cond, mem_read, mem_write,
                             ir_write, reg_write, i_or_d}), 17'b10000000);
            stepClock();
        end

        applyStimulus(ADD, 1'b0, 1'b0, 1'b1);
        reset = 1'b1;
        #1;
        checkOutput("resetClearsHalt", 17'({is_halted, mem_read, ir_write}), 17'b010);
        stepClock();
        reset = 1'b0;
        cycle(ADD, 1'b0, 1'b0, 1'b1);
        applyStimulus(ADD, 1'b0, 1'b0, 1'b1);
        checkOutput("decodeAfterHalt", 17'({alu_src_a, alu_src_b, is_halted}), 17'b01100);
        stepClock();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
